// File: rtl/mem_store_forward.sv
// rtl/mem_store_forward.sv - MEM-stage load-to-store data forwarding with MEM/WB capture register
// Optional macro FWD_COUNT_EN adds a saturating 16-bit forward-event counter (fwd_count).
module mem_store_forward #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_reg_write,
    input  logic              mem_mem_to_reg,
    input  logic              mem_write,
    input  logic [REG_W-1:0]  mem_rt,
    input  logic [DATA_W-1:0] mem_store_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] sel_data,
    output logic              fwd,
`ifdef FWD_COUNT_EN
    output logic [15:0]       fwd_count,
`endif
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [REG_W-1:0]  wb_write_reg,
    output logic [DATA_W-1:0] wb_rd_data
);

    logic              wb_reg_write_q,  wb_reg_write_d;
    logic              wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic [REG_W-1:0]  wb_write_reg_q,  wb_write_reg_d;
    logic [DATA_W-1:0] wb_rd_data_q,    wb_rd_data_d;

    always_comb begin
        wb_reg_write_d  = mem_reg_write;
        wb_mem_to_reg_d = mem_mem_to_reg;
        wb_write_reg_d  = mem_rt;
        wb_rd_data_d    = mem_rd_data;
        // Only a load one instruction back can supply store data; r0 is hardwired zero.
        fwd = mem_write & wb_reg_write_q & wb_mem_to_reg_q
            & (wb_write_reg_q == mem_rt) & (wb_write_reg_q != '0);
        sel_data = fwd ? wb_rd_data_q : mem_store_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_reg_write_q  <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            wb_write_reg_q  <= '0;
            wb_rd_data_q    <= '0;
        end else begin
            wb_reg_write_q  <= wb_reg_write_d;
            wb_mem_to_reg_q <= wb_mem_to_reg_d;
            wb_write_reg_q  <= wb_write_reg_d;
            wb_rd_data_q    <= wb_rd_data_d;
        end
    end

    assign wb_reg_write  = wb_reg_write_q;
    assign wb_mem_to_reg = wb_mem_to_reg_q;
    assign wb_write_reg  = wb_write_reg_q;
    assign wb_rd_data    = wb_rd_data_q;

`ifdef FWD_COUNT_EN
    logic [15:0] fwd_count_q, fwd_count_d;

    always_comb begin
        fwd_count_d = fwd_count_q;
        if (fwd && (fwd_count_q != 16'hFFFF)) begin
            fwd_count_d = fwd_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_count_q <= 16'd0;
        end else begin
            fwd_count_q <= fwd_count_d;
        end
    end

    assign fwd_count = fwd_count_q;
`endif

endmodule

// File: tb/tb_mem_store_forward.sv
// tb/tb_mem_store_forward.sv - scoreboard bench for mem_store_forward against a previous-instruction model
module tb_mem_store_forward;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic        wr;
        logic [4:0]  rt;
        logic [31:0] sd;
        logic [31:0] rd;
    } instr_t;

    typedef struct packed {
        logic        fwd;
        logic [31:0] sel;
        logic        rw;
        logic        m2r;
        logic [4:0]  wreg;
        logic [31:0] data;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_reg_write = 1'b0;
    logic        mem_mem_to_reg = 1'b0;
    logic        mem_write = 1'b0;
    logic [4:0]  mem_rt = 5'd0;
    logic [31:0] mem_store_data = 32'h01010101;
    logic [31:0] mem_rd_data = 32'd0;
    logic [31:0] sel_data;
    logic        fwd;
    logic        wb_reg_write;
    logic        wb_mem_to_reg;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_rd_data;
`ifdef FWD_COUNT_EN
    logic [15:0] fwd_count;
`endif

    mem_store_forward #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .mem_reg_write(mem_reg_write),
        .mem_mem_to_reg(mem_mem_to_reg),
        .mem_write(mem_write),
        .mem_rt(mem_rt),
        .mem_store_data(mem_store_data),
        .mem_rd_data(mem_rd_data),
        .sel_data(sel_data),
        .fwd(fwd),
`ifdef FWD_COUNT_EN
        .fwd_count(fwd_count),
`endif
        .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg),
        .wb_write_reg(wb_write_reg),
        .wb_rd_data(wb_rd_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    exp_t q[$];
    instr_t prev;
    int unsigned cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Model: the only state that matters is the previous instruction and the forward tally.
    task automatic issue(input instr_t c, input bit mid_rst);
        exp_t e;
        @(posedge clk);
        #1;
        mem_reg_write  = c.rw;
        mem_mem_to_reg = c.m2r;
        mem_write      = c.wr;
        mem_rt         = c.rt;
        mem_store_data = c.sd;
        mem_rd_data    = c.rd;
        if (mid_rst) begin
            #1;
            rst  = 1'b1;
            prev = '0;
            cnt  = 0;
        end
        e.fwd  = c.wr && prev.rw && prev.m2r && (prev.rt == c.rt) && (prev.rt != 5'd0);
        e.sel  = e.fwd ? prev.rd : c.sd;
        e.rw   = prev.rw;
        e.m2r  = prev.m2r;
        e.wreg = prev.rt;
        e.data = prev.rd;
        e.cnt  = cnt[15:0];
        q.push_back(e);
        if (e.fwd && cnt < 65535) cnt++;
        prev = c;
        if (mid_rst) begin
            @(negedge clk);
            #1;
            rst = 1'b0;
        end
    endtask

    function automatic instr_t mk(input logic rw, input logic m2r, input logic wr,
                                  input logic [4:0] rt, input logic [31:0] sd, input logic [31:0] rd);
        instr_t i;
        i.rw = rw; i.m2r = m2r; i.wr = wr; i.rt = rt; i.sd = sd; i.rd = rd;
        return i;
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("fwd", {31'd0, fwd}, {31'd0, e.fwd});
            chk("sel_data", sel_data, e.sel);
            chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e.rw});
            chk("wb_mem_to_reg", {31'd0, wb_mem_to_reg}, {31'd0, e.m2r});
            chk("wb_write_reg", {27'd0, wb_write_reg}, {27'd0, e.wreg});
            chk("wb_rd_data", wb_rd_data, e.data);
`ifdef FWD_COUNT_EN
            chk("fwd_count", {16'd0, fwd_count}, {16'd0, e.cnt});
`endif
        end
    end

    initial begin
        #3;
        chk("rst_fwd", {31'd0, fwd}, 32'd0);
        chk("rst_sel_data", sel_data, 32'h01010101);
        chk("rst_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
        chk("rst_wb_mem_to_reg", {31'd0, wb_mem_to_reg}, 32'd0);
        chk("rst_wb_write_reg", {27'd0, wb_write_reg}, 32'd0);
        chk("rst_wb_rd_data", wb_rd_data, 32'd0);
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        prev = mk(0, 0, 0, 5'd0, 32'h01010101, 32'd0);

        // Load-then-store hit, register mismatch
        issue(mk(1, 1, 0, 5'b11000, 32'h0, 32'hDEADBEEF), 0);
        issue(mk(0, 0, 1, 5'b11000, 32'h01010111, 32'h12345678), 0);
        issue(mk(1, 1, 0, 5'b11000, 32'h0, 32'hDEADBEEF), 0);
        issue(mk(0, 0, 1, 5'b11011, 32'h01010111, 32'h0), 0);
        // Non-load producer, load without RegWrite
        issue(mk(1, 0, 0, 5'd9, 32'h0, 32'hAAAA5555), 0);
        issue(mk(0, 0, 1, 5'd9, 32'h22222222, 32'h0), 0);
        issue(mk(0, 1, 0, 5'd9, 32'h0, 32'hBBBB0000), 0);
        issue(mk(0, 0, 1, 5'd9, 32'h33333333, 32'h0), 0);
        // Register zero, non-store after matching load
        issue(mk(1, 1, 0, 5'd0, 32'h0, 32'hCAFEF00D), 0);
        issue(mk(0, 0, 1, 5'd0, 32'h44444444, 32'h0), 0);
        issue(mk(1, 1, 0, 5'd4, 32'h0, 32'hFEEDFACE), 0);
        issue(mk(1, 0, 0, 5'd4, 32'h55555555, 32'h0), 0);
        // Match two instructions back is not forwarded
        issue(mk(1, 1, 0, 5'd6, 32'h0, 32'h0BADF00D), 0);
        issue(mk(0, 0, 0, 5'd1, 32'h0, 32'h0), 0);
        issue(mk(0, 0, 1, 5'd6, 32'h66666666, 32'h0), 0);
        // Three back-to-back load/store pairs, including simultaneous load+store in MEM
        for (int i = 0; i < 3; i++) begin
            issue(mk(1, 1, 0, 5'd12, 32'h0, 32'h70000000 + i), 0);
            issue(mk(0, 0, 1, 5'd12, 32'h77777777, 32'h0), 0);
        end
        issue(mk(1, 1, 1, 5'd13, 32'h88888888, 32'h13131313), 0);
        issue(mk(1, 1, 1, 5'd13, 32'h99999999, 32'h14141414), 0);
        // Reset mid-cycle discards a pending forward
        issue(mk(1, 1, 0, 5'd20, 32'h0, 32'hABCDABCD), 0);
        issue(mk(0, 0, 1, 5'd20, 32'hDCBADCBA, 32'h0), 1);
        issue(mk(0, 0, 1, 5'd20, 32'h10101010, 32'h0), 0);

        for (int i = 0; i < 400; i++) begin
            issue(mk($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                     5'($urandom_range(0, 3)), $urandom, $urandom), ($urandom_range(0, 39) == 0));
        end

`ifdef FWD_COUNT_EN
        for (int i = 0; i < 65540; i++) begin
            issue(mk(1, 1, 1, 5'd7, 32'h0, 32'h00C0FFEE), 0);
        end
`endif

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
